// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter that feeds the display digit
// multiplexer. It uses the shift-add-3 (double-dabble) method and
// processes one input bit per clock.
//
// Outputs are registered and change only when a conversion completes.
// This lets the scan logic always see a coherent 4-digit value.
//
// Ports
//   clk     : system clock, all logic on the rising edge
//   reset   : synchronous, active-high reset; dominant over everything
//   start   : conversion request; accepted only while idle
//   bin_in  : unsigned binary value, sampled on the accepted start cycle
//   busy    : high while the shift phase is running
//   done    : one-cycle pulse when new digits become valid
//   ovf     : last accepted value exceeded MAX_VAL (clamped to MAX_VAL)
//   dig_U   : BCD units digit
//   dig_D   : BCD tens digit
//   dig_C   : BCD hundreds digit
//   dig_M   : BCD thousands digit
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int IN_W    = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [3:0]      dig_U,
    output logic [3:0]      dig_D,
    output logic [3:0]      dig_C,
    output logic [3:0]      dig_M
);

    localparam int          CNT_W  = $clog2(IN_W + 1);
    localparam int          WORK_W = 16 + IN_W;
    localparam logic [31:0] MAX_U  = 32'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORK_W-1:0] work;        // {BCD[15:0], binary[IN_W-1:0]}
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pending;
    logic              sat;

    // Add-3 correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] adj_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // One double-dabble step: correct all four BCD nibbles, then shift left.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            r[IN_W + 4*i +: 4] = adj_nibble(w[IN_W + 4*i +: 4]);
        end
        return {r[WORK_W-2:0], 1'b0};
    endfunction

    // For IN_W < 14 the input cannot exceed 9999, so this is constant false.
    assign sat  = ({{(32-IN_W){1'b0}}, bin_in} > MAX_U);
    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // The counter still holds 1 during the final shift.
                if (cnt == CNT_W'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work        <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            ovf         <= 1'b0;
            done        <= 1'b0;
            dig_U       <= 4'd0;
            dig_D       <= 4'd0;
            dig_C       <= 4'd0;
            dig_M       <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work        <= {16'd0, (sat ? MAX_U[IN_W-1:0] : bin_in)};
                        ovf_pending <= sat;
                        cnt         <= CNT_W'(IN_W);
                    end
                end
                SHIFT: begin
                    work <= dabble_step(work);
                    cnt  <= cnt - CNT_W'(1);
                end
                FINISH: begin
                    dig_U <= work[IN_W      +: 4];
                    dig_D <= work[IN_W + 4  +: 4];
                    dig_C <= work[IN_W + 8  +: 4];
                    dig_M <= work[IN_W + 12 +: 4];
                    ovf   <= ovf_pending;
                    done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    localparam int IN_W = 14;

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic            ovf;
    logic [3:0]      dig_U;
    logic [3:0]      dig_D;
    logic [3:0]      dig_C;
    logic [3:0]      dig_M;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    exp_t        sb[$];
    logic [15:0] prev_dig;
    logic        prev_ovf;

    bin_to_bcd_seq #(.IN_W(IN_W), .MAX_VAL(9999)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .dig_U  (dig_U),
        .dig_D  (dig_D),
        .dig_C  (dig_C),
        .dig_M  (dig_M)
    );

    always #5 clk = ~clk;

    // Reference: clamp to 9999, then split into decimal digits arithmetically.
    function automatic logic [15:0] model(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("sb_has_entry_at_done", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("digits_at_done", 32'({dig_M, dig_C, dig_D, dig_U}), 32'(e.dig));
                check("ovf_at_done", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic start_conv(input int v);
        @(negedge clk);
        bin_in = v[IN_W-1:0];
        start  = 1'b1;
        sb.push_back('{dig: model(v), ovf: (v > 9999)});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one conversion; optionally pulses start with inj_val at negedge inj_at.
    task automatic conv(input string tag, input int v, input int inj_at, input int inj_val);
        int   n;
        int   busy_n;
        logic held;
        n      = 0;
        busy_n = 0;
        held   = 1'b1;
        start_conv(v);
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_n++;
            if ({dig_M, dig_C, dig_D, dig_U} !== prev_dig || ovf !== prev_ovf) held = 1'b0;
            if (n == inj_at) begin
                bin_in = inj_val[IN_W-1:0];
                start  = 1'b1;
            end else if (n == inj_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(IN_W + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(IN_W));
        check({tag, "_busy_low_at_done"}, 32'(busy), 32'd0);
        check({tag, "_outputs_held"}, 32'(held), 32'd1);
        prev_dig = model(v);
        prev_ovf = (v > 9999);
    endtask

    initial begin
        int n;
        int m;
        int extra;

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check("reset_digits", 32'({dig_M, dig_C, dig_D, dig_U}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        reset    = 1'b0;
        prev_dig = 16'h0000;
        prev_ovf = 1'b0;

        conv("zero",  0,     -10, 0);
        conv("v1234", 1234,  -10, 0);
        conv("v9999", 9999,  -10, 0);
        conv("v5",    5,     -10, 0);
        conv("v10",   10,    -10, 0);
        conv("v12000", 12000, -10, 0);
        conv("v16383", 16383, -10, 0);
        conv("v42",   42,    -10, 0);

        // start pulsed mid-conversion (sampled at edge 5) must be ignored.
        conv("v7777", 7777, 4, 1111);
        repeat (20) @(negedge clk);
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_digits", 32'({dig_M, dig_C, dig_D, dig_U}), 32'h7777);

        // Reset at edge 7 aborts 4321.
        start_conv(4321);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        check("abort_digits", 32'({dig_M, dig_C, dig_D, dig_U}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        extra = done_cnt;
        repeat (25) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - extra), 32'd0);
        prev_dig = 16'h0000;
        prev_ovf = 1'b0;
        conv("v56", 56, -10, 0);

        // start held high: second conversion accepted on the done cycle.
        @(negedge clk);
        bin_in = 14'd99;
        start  = 1'b1;
        sb.push_back('{dig: model(99), ovf: 1'b0});
        sb.push_back('{dig: model(99), ovf: 1'b0});
        @(negedge clk);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 32'(n), 32'(IN_W + 1));
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (done !== 1'b1 && m < 40);
        start = 1'b0;
        check("b2b_second_spacing", 32'(m), 32'(IN_W + 2));

        repeat (25) @(negedge clk);
        check("final_busy_idle", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("done_pulse_count", 32'(done_cnt), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog: guarantees termination even if a wait loop stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
